// File: rtl/bias_estimator.sv
// rtl/bias_estimator.sv - windowed mean of a signed sample stream for bias calibration
//
// On a start pulse, averages the next 2^SampleBits signed samples and presents
// the floor mean as a single-beat valid/ready result. Input data is consumed,
// never passed through.
//
// Ports:
//   aclk        clock, rising edge
//   aresetn     asynchronous active-low reset
//   start       single-cycle request to begin/restart a measurement
//   in_tvalid   input sample valid
//   in_tready   input sample accepted (low while a result is pending)
//   in_tdata    signed input sample
//   out_tvalid  bias result valid
//   out_tready  downstream accepts the result
//   out_tdata   signed bias result (window mean, floor)
//   busy        measurement in progress or result pending

module bias_estimator #(
  parameter int DataWidth  = 24,
  parameter int SampleBits = 12
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  input  logic [DataWidth-1:0] in_tdata,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic [DataWidth-1:0] out_tdata,
  output logic                 busy
);

  localparam int AccWidth = DataWidth + SampleBits;
  localparam logic [SampleBits-1:0] CntMax = '1;
  localparam logic [SampleBits-1:0] CntOne = SampleBits'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [AccWidth-1:0] acc;
  logic signed [AccWidth-1:0] sample_ext;
  logic signed [AccWidth-1:0] sum;
  logic [SampleBits-1:0]      cnt;
  logic                       accept;
  logic                       last_beat;

  // in_tready decodes straight from the state register so a pending result
  // back-pressures upstream without any input-to-output path.
  assign in_tready  = (state != DONE);
  assign accept     = in_tvalid & in_tready;
  assign sample_ext = {{SampleBits{in_tdata[DataWidth-1]}}, in_tdata};
  assign sum        = acc + sample_ext;
  // A start in ACCUM takes priority, so the beat in that cycle never completes a window.
  assign last_beat  = (state == ACCUM) && !start && accept && (cnt == CntMax);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (last_beat) state_nxt = DONE;
      DONE:    if (out_tvalid && out_tready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        ACCUM: begin
          if (start) begin
            acc <= '0;
            cnt <= '0;
          end else if (accept) begin
            acc <= sum;
            cnt <= cnt + CntOne;  // wraps to 0 on the last beat
            if (cnt == CntMax) begin
              // Arithmetic shift gives floor division; the mean always fits DataWidth.
              out_tdata  <= DataWidth'(sum >>> SampleBits);
              out_tvalid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_tready) out_tvalid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_estimator.sv
// tb/tb_bias_estimator.sv - scoreboard bench for bias_estimator (DataWidth=24, SampleBits=4)

module tb_bias_estimator;

  localparam int DW = 24;
  localparam int SB = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          start;
  logic          in_tvalid;
  logic          in_tready;
  logic [DW-1:0] in_tdata;
  logic          out_tvalid;
  logic          out_tready;
  logic [DW-1:0] out_tdata;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] sb_q[$];

  always #5 aclk = ~aclk;

  bias_estimator #(.DataWidth(DW), .SampleBits(SB)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .start      (start),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tdata   (in_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tdata  (out_tdata),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result monitor: one pop per handshake, sampled on the falling edge.
  always @(negedge aclk) begin
    if (aresetn && out_tvalid && out_tready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'(out_tdata), 32'hFFFF_FFFF);
      end else begin
        logic [DW-1:0] exp_v;
        exp_v = sb_q.pop_front();
        check("result", 32'(out_tdata), 32'(exp_v));
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One beat; always accepted in IDLE/ACCUM since in_tready is then 1.
  task automatic beat(input int v);
    in_tvalid = 1'b1;
    in_tdata  = v[DW-1:0];
    tick();
    in_tvalid = 1'b0;
  endtask

  task automatic window(input int v, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      beat(v);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    aresetn    = 1'b0;
    start      = 1'b0;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    out_tready = 1'b1;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    check("rst_out_tvalid", 32'(out_tvalid), 32'd0);
    check("rst_out_tdata",  32'(out_tdata),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_in_tready",  32'(in_tready),  32'd1);

    // Constant input
    sb_q.push_back(24'd100);
    pulse_start();
    check("const_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 15; i++) beat(100);
    check("const_valid_early", 32'(out_tvalid), 32'd0);
    beat(100);
    check("const_valid_after_last", 32'(out_tvalid), 32'd1);
    check("const_in_tready_low",    32'(in_tready),  32'd0);
    tick();
    check("const_busy_after_hs",  32'(busy),       32'd0);
    check("const_valid_after_hs", 32'(out_tvalid), 32'd0);

    // Negative rounding: sum -56, floor mean -4
    sb_q.push_back(24'hFFFFFC);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      beat(-3);
      beat(-4);
    end
    wait_idle("neg_idle");

    // Extremes
    sb_q.push_back(24'h7FFFFF);
    pulse_start();
    window(32'h007FFFFF, 1'b0);
    wait_idle("maxpos_idle");
    sb_q.push_back(24'h800000);
    pulse_start();
    window(32'h00800000, 1'b0);
    wait_idle("maxneg_idle");

    // Random gaps, then held result under back-pressure
    sb_q.push_back(24'd50);
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      beat(50);
    end
    out_tready = 1'b0;
    beat(50);
    in_tvalid = 1'b1;
    in_tdata  = 24'd999;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",    32'(out_tvalid), 32'd1);
      check("bp_data",     32'(out_tdata),  32'd50);
      check("bp_in_tready", 32'(in_tready), 32'd0);
      tick();
    end
    in_tvalid  = 1'b0;
    out_tready = 1'b1;
    wait_idle("bp_idle");

    // Idle discard and restart (beat in the start cycle is dropped)
    for (int i = 0; i < 10; i++) beat(1000);
    check("idle_discard_valid", 32'(out_tvalid), 32'd0);
    check("idle_discard_busy",  32'(busy),       32'd0);
    sb_q.push_back(24'd10);
    pulse_start();
    for (int i = 0; i < 7; i++) beat(1000);
    start     = 1'b1;
    in_tvalid = 1'b1;
    in_tdata  = 24'd1000;
    tick();
    start     = 1'b0;
    in_tvalid = 1'b0;
    window(10, 1'b0);
    wait_idle("restart_idle");

    // Asynchronous reset mid-window
    pulse_start();
    for (int i = 0; i < 9; i++) beat(5);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_busy",      32'(busy),       32'd0);
    check("arst_in_tready", 32'(in_tready),  32'd1);
    check("arst_valid",     32'(out_tvalid), 32'd0);
    check("arst_data",      32'(out_tdata),  32'd0);
    tick();
    aresetn = 1'b1;
    tick();
    sb_q.push_back(24'hFFFFF9);
    pulse_start();
    window(-7, 1'b1);
    wait_idle("post_rst_idle");

    repeat (3) tick();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
